// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU result types and flag bit positions
package alu_pkg;

    localparam int ALU_W     = 4;
    localparam int CARRY_BIT = ALU_W;
    localparam int ZERO_BIT  = ALU_W + 1;

    typedef struct packed {
        logic             zero;
        logic             carry;
        logic [ALU_W-1:0] data;
    } alu_result_t;

endpackage

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - FIFO capturing ALU results with sticky overflow on drop
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = ALU_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    input  logic                       in_carry,
    input  logic                       in_zero,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW+1:0]              out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Entry layout {zero, carry, data} matches alu_result_t when DW == ALU_W.
    logic [DW+1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [DW+1:0] wr_entry;

    // Handshake, pointer, occupancy and overflow next-state logic.
    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        // A pop on a full FIFO frees the slot, so the ALU push still lands this cycle.
        in_ready  = !rst && (!full || out_ready);
        out_valid = !rst && !empty;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // The ALU cannot stall: anything offered while not ready is lost.
        drop      = !rst && in_valid && !in_ready;
        wr_entry  = {in_zero, in_carry, in_data};

        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Setting wins over clearing so a drop in the clear cycle is never lost.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        out_data = out_valid ? mem_q[rd_ptr_q] : '0;
        count    = count_q;
        overflow = ovf_q;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array write; contents need no reset since out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed self-checking bench for alu_result_buffer
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_carry;
    logic       in_zero;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_data;
    logic [2:0] count;
    logic       overflow;
    logic       clr_ovf;

    int total = 0;
    int bad   = 0;

    alu_result_buffer #(.DEPTH(4), .DW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_carry  (in_carry),
        .in_zero   (in_zero),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] mk(input logic z, input logic c, input logic [3:0] d);
        alu_result_t r;
        r.zero  = z;
        r.carry = c;
        r.data  = d;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 4'h5; in_carry = 1'b1; in_zero = 1'b1;
        out_ready = 1'b0; clr_ovf = 1'b0;
        tick();
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 6'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_nothing_stored: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_pass();
        in_valid = 1'b1; in_data = 4'h9; in_carry = 1'b1; in_zero = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
        total++; if (out_data !== 6'b01_1001) begin bad++; $display("FAIL single_out_data: got %b want 011001", out_data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_pop_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 6'h00) begin bad++; $display("FAIL single_gated_data: got %h want 00", out_data); end
    endtask

    task automatic test_empty_pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_pop_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL empty_pop_valid: got %b want 0", out_valid); end
    endtask

    task automatic fill(input logic [3:0] base);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = base + 4'(i); in_carry = i[0]; in_zero = i[1];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill_and_overflow();
        fill(4'h1);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count: got %0d want 4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b1; in_data = 4'hF; in_carry = 1'b0; in_zero = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_count: got %0d want 4", count); end
        in_valid = 1'b1; in_data = 4'hE; clr_ovf = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_priority: got %b want 1", overflow); end
        tick();
        clr_ovf = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        // Drained order must be 1,2,3,4 with flags from fill(); dropped F/E never appear.
        for (int i = 0; i < 4; i++) begin
            logic [5:0] exp;
            exp = mk(i[1], i[0], 4'(i + 1));
            total++; if (out_data !== exp) begin bad++; $display("FAIL order_%0d: got %h want %h", i, out_data, exp); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count: got %0d want 0", count); end
    endtask

    task automatic test_full_push_pop();
        fill(4'h5);
        in_valid = 1'b1; in_data = 4'hA; in_carry = 1'b1; in_zero = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_pp_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_pp_count: got %0d want 4", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pp_ovf: got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            logic [5:0] exp;
            exp = (i == 3) ? mk(1'b1, 1'b1, 4'hA) : mk(4'(i+1) >= 4'd2, (i % 2) == 0, 4'(6 + i));
            total++; if (out_data !== exp) begin bad++; $display("FAIL full_pp_order_%0d: got %h want %h", i, out_data, exp); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [5:0] exp_q[$];
        logic [5:0] e;
        // Push and pop together on empty: push stored, no pop.
        in_valid = 1'b1; in_data = 4'h3; in_carry = 1'b0; in_zero = 1'b1; out_ready = 1'b1;
        exp_q.push_back(mk(1'b1, 1'b0, 4'h3));
        tick();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL empty_pp_count: got %0d want 1", count); end
        for (int k = 0; k < 10; k++) begin
            in_data = 4'(k + 4); in_carry = k[0]; in_zero = k[1];
            e = exp_q.pop_front();
            exp_q.push_back(mk(k[1], k[0], 4'(k + 4)));
            total++; if (out_data !== e) begin bad++; $display("FAIL wrap_%0d: got %h want %h", k, out_data, e); end
            tick();
        end
        out_ready = 1'b0;
        in_data = 4'h0; in_carry = 1'b0; in_zero = 1'b0;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count: got %0d want 2", count); end
        rst = 1'b1; in_valid = 1'b1;
        tick();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_release_valid: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_empty_pop();
        test_fill_and_overflow();
        test_full_push_pop();
        test_wrap_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
